// File: rtl/ant_pkg.sv
// Shared types and constants for the ant sprite walkers.
package ant_pkg;

   typedef enum logic [1:0] {
      RIGHT = 2'd0,
      LEFT  = 2'd1,
      DOWN  = 2'd2,
      UP    = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_MOVE  = 2'd2,
      S_TURN  = 2'd3
   } state_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int DIRT_TOP = 240;

   // Right-shifting Fibonacci form: bits 0,2,3,5 correspond to taps 16,14,13,11
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic dir_t dir_reverse(input dir_t d);
      dir_t r;
      case (d)
         RIGHT:   r = LEFT;
         LEFT:    r = RIGHT;
         DOWN:    r = UP;
         default: r = DOWN;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ant_walker_lfsr16.sv
// 16-bit Fibonacci LFSR that shifts only when asked; one per ant.
module lfsr16
   import ant_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        CLK,
   input  logic        RST_BTN,
   input  logic        i_adv,
   output logic [15:0] o_state
);

   logic [15:0] r_state;
   logic        w_fb;

   assign w_fb    = ^(r_state & LFSR_TAPS);
   assign o_state = r_state;

   always_ff @(posedge CLK or negedge RST_BTN) begin
      if (!RST_BTN)
         r_state <= SEED;
      else if (i_adv)
         r_state <= {w_fb, r_state[15:1]};
   end

endmodule

// File: rtl/ant_walker.sv
// One ant: steps across the dirt band during blanking and flags raster pixels inside its sprite.
//
// state   | meaning
// IDLE    | wait for an enabled animation tick (advances the LFSR)
// COUNT   | count ticks; every FRAMES_PER_STEP-th tick goes on to MOVE
// MOVE    | commit the stepped position, or reverse heading at a band edge
// TURN    | occasionally pick a new heading from the LFSR
module ant_walker
   import ant_pkg::*;
#(
   parameter int          ANT_W           = 16,
   parameter int          ANT_H           = 8,
   parameter int          X_MIN           = 0,
   parameter int          X_MAX           = SCREEN_W - 1,
   parameter int          Y_MIN           = DIRT_TOP,
   parameter int          Y_MAX           = SCREEN_H - 1,
   parameter int          X_START         = 400,
   parameter int          Y_START         = 456,
   parameter int          STEP            = 2,
   parameter int          FRAMES_PER_STEP = 4,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic       CLK,
   input  logic       RST_BTN,
   input  logic       i_pix_stb,
   input  logic       i_animate,
   input  logic       i_en,
   input  logic [9:0] i_x,
   input  logic [8:0] i_y,
   output logic       o_ant,
   output logic [9:0] o_ant_x,
   output logic [8:0] o_ant_y,
   output logic [1:0] o_dir
);

   localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

   // Box limits expressed on the top-left corner, so only the corner is tested
   localparam logic signed [10:0] STEP_S   = 11'(STEP);
   localparam logic signed [10:0] X_LO_S   = 11'(X_MIN);
   localparam logic signed [10:0] X_HI_S   = 11'(X_MAX - ANT_W + 1);
   localparam logic signed [10:0] Y_LO_S   = 11'(Y_MIN);
   localparam logic signed [10:0] Y_HI_S   = 11'(Y_MAX - ANT_H + 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [9:0]       r_x;
   logic [8:0]       r_y;
   dir_t             r_dir;
   logic             r_ant;

   logic [15:0]        w_lfsr;
   logic               w_adv;
   logic               w_unused_lfsr;
   logic signed [10:0] w_nx;
   logic signed [10:0] w_ny;
   logic               w_fit;
   logic [10:0]        w_px;
   logic [10:0]        w_py;
   logic [10:0]        w_ax;
   logic [10:0]        w_ay;
   logic               w_hit;

   assign w_adv         = (r_state == S_IDLE) && i_animate && i_en;
   assign w_unused_lfsr = ^w_lfsr[15:6];

   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .CLK     (CLK),
      .RST_BTN (RST_BTN),
      .i_adv   (w_adv),
      .o_state (w_lfsr)
   );

   always_comb begin
      w_nx = $signed({1'b0, r_x});
      w_ny = $signed({2'b00, r_y});
      case (r_dir)
         RIGHT:   w_nx = $signed({1'b0, r_x}) + STEP_S;
         LEFT:    w_nx = $signed({1'b0, r_x}) - STEP_S;
         DOWN:    w_ny = $signed({2'b00, r_y}) + STEP_S;
         default: w_ny = $signed({2'b00, r_y}) - STEP_S;
      endcase
   end

   assign w_fit = (w_nx >= X_LO_S) && (w_nx <= X_HI_S) &&
                  (w_ny >= Y_LO_S) && (w_ny <= Y_HI_S);

   assign w_px  = {1'b0, i_x};
   assign w_py  = {2'b00, i_y};
   assign w_ax  = {1'b0, r_x};
   assign w_ay  = {2'b00, r_y};
   assign w_hit = (w_px >= w_ax) && (w_px < w_ax + 11'(ANT_W)) &&
                  (w_py >= w_ay) && (w_py < w_ay + 11'(ANT_H));

   always_ff @(posedge CLK or negedge RST_BTN) begin
      if (!RST_BTN) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_x     <= 10'(X_START);
         r_y     <= 9'(Y_START);
         r_dir   <= LEFT;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_adv)
                  r_state <= S_COUNT;
            end
            S_COUNT: begin
               if (r_cnt == CNT_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_MOVE;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_state <= S_IDLE;
               end
            end
            S_MOVE: begin
               if (w_fit) begin
                  r_x     <= w_nx[9:0];
                  r_y     <= w_ny[8:0];
                  r_state <= S_TURN;
               end else begin
                  r_dir   <= dir_reverse(r_dir);
                  r_state <= S_IDLE;
               end
            end
            default: begin
               if (w_lfsr[3:0] == 4'd0)
                  r_dir <= dir_t'(w_lfsr[5:4]);
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_BTN) begin
      if (!RST_BTN)
         r_ant <= 1'b0;
      else if (i_pix_stb)
         r_ant <= w_hit;
   end

   assign o_ant   = r_ant;
   assign o_ant_x = r_x;
   assign o_ant_y = r_y;
   assign o_dir   = r_dir;

endmodule

// File: tb/tb_ant_walker.sv
// Directed bench for ant_walker: reset, hit edges, step cadence, band edge, enable/drop, mid-move reset.
module tb_ant_walker;

   logic       CLK       = 1'b0;
   logic       RST_BTN   = 1'b0;
   logic       i_pix_stb = 1'b0;
   logic       i_animate = 1'b0;
   logic       e_animate = 1'b0;
   logic       i_en      = 1'b0;
   logic [9:0] i_x       = '0;
   logic [8:0] i_y       = '0;

   logic       o_ant, e_ant;
   logic [9:0] o_ant_x, e_x;
   logic [8:0] o_ant_y, e_y;
   logic [1:0] o_dir, e_dir;

   int n_total = 0;
   int n_bad   = 0;

   always #5 CLK = ~CLK;

   ant_walker dut (
      .CLK       (CLK),
      .RST_BTN   (RST_BTN),
      .i_pix_stb (i_pix_stb),
      .i_animate (i_animate),
      .i_en      (i_en),
      .i_x       (i_x),
      .i_y       (i_y),
      .o_ant     (o_ant),
      .o_ant_x   (o_ant_x),
      .o_ant_y   (o_ant_y),
      .o_dir     (o_dir)
   );

   // Second ant starting on the left edge, heading LEFT
   ant_walker #(
      .X_START (0)
   ) u_edge (
      .CLK       (CLK),
      .RST_BTN   (RST_BTN),
      .i_pix_stb (i_pix_stb),
      .i_animate (e_animate),
      .i_en      (i_en),
      .i_x       (i_x),
      .i_y       (i_y),
      .o_ant     (e_ant),
      .o_ant_x   (e_x),
      .o_ant_y   (e_y),
      .o_dir     (e_dir)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic pulse();
      @(negedge CLK);
      i_animate = 1'b1;
      @(negedge CLK);
      i_animate = 1'b0;
   endtask

   task automatic tick();
      pulse();
      idle(4);
   endtask

   task automatic etick();
      @(negedge CLK);
      e_animate = 1'b1;
      @(negedge CLK);
      e_animate = 1'b0;
      idle(4);
   endtask

   task automatic strobe(input int x, input int y);
      @(negedge CLK);
      i_x       = 10'(x);
      i_y       = 9'(y);
      i_pix_stb = 1'b1;
      @(negedge CLK);
      i_pix_stb = 1'b0;
   endtask

   initial begin
      idle(3);
      RST_BTN = 1'b1;
      idle(2);

      chk("rst_x",    o_ant_x, 400);
      chk("rst_y",    o_ant_y, 456);
      chk("rst_dir",  o_dir, 1);
      chk("rst_ant",  o_ant, 0);
      chk("rst_lfsr", dut.w_lfsr, 16'hACE1);

      strobe(400, 456); chk("hit_tl", o_ant, 1);
      strobe(415, 463); chk("hit_br", o_ant, 1);
      @(negedge CLK);
      i_x = 10'd0;
      idle(2);
      chk("hit_hold", o_ant, 1);
      strobe(416, 456); chk("hit_right_out", o_ant, 0);
      strobe(399, 463); chk("hit_left_out",  o_ant, 0);
      strobe(400, 464); chk("hit_below_out", o_ant, 0);

      i_en = 1'b1;
      repeat (4) etick();
      chk("edge_x_hold", e_x, 0);
      chk("edge_dir",    e_dir, 0);
      repeat (4) etick();
      chk("edge_x_step", e_x, 2);

      repeat (3) tick();
      chk("cad_x_3",   o_ant_x, 400);
      chk("cad_cnt_3", dut.r_cnt, 3);
      pulse();
      chk("cad_x_e0", o_ant_x, 400);
      @(negedge CLK);
      chk("cad_x_e1", o_ant_x, 400);
      @(negedge CLK);
      chk("cad_x_e2", o_ant_x, 398);
      @(negedge CLK);
      chk("cad_y",    o_ant_y, 456);
      chk("cad_dir",  o_dir, 1);
      chk("cad_lfsr", dut.w_lfsr, 16'h2ACE);
      idle(2);

      i_en = 1'b0;
      repeat (10) tick();
      chk("dis_x",    o_ant_x, 398);
      chk("dis_lfsr", dut.w_lfsr, 16'h2ACE);
      chk("dis_cnt",  dut.r_cnt, 0);
      i_en = 1'b1;

      @(negedge CLK);
      i_animate = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      i_animate = 1'b0;
      idle(4);
      chk("drop_cnt",  dut.r_cnt, 1);
      chk("drop_lfsr", dut.w_lfsr, 16'h1567);

      strobe(398, 456); chk("pre_rst_ant", o_ant, 1);
      repeat (2) tick();
      chk("pre_rst_cnt", dut.r_cnt, 3);
      pulse();
      @(negedge CLK);
      chk("in_move", dut.r_state, 2);
      #1 RST_BTN = 1'b0;
      #1;
      chk("mr_x",    o_ant_x, 400);
      chk("mr_y",    o_ant_y, 456);
      chk("mr_dir",  o_dir, 1);
      chk("mr_ant",  o_ant, 0);
      chk("mr_lfsr", dut.w_lfsr, 16'hACE1);
      idle(2);
      chk("mr_x_held", o_ant_x, 400);
      RST_BTN = 1'b1;
      idle(1);

      repeat (3) tick();
      chk("post_x_3", o_ant_x, 400);
      tick();
      chk("post_x",    o_ant_x, 398);
      chk("post_dir",  o_dir, 1);
      chk("post_lfsr", dut.w_lfsr, 16'h2ACE);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
